dual_stepper_driver: RTL and testbench

Downstream stage of the SCARA controller. Consumes the per-move step counts and directions (`steps1`, `steps2`, `dir1`, `dir2`, `dataReady`) and emits timed STEP/DIR pulses to the two joint stepper drivers. Raises `stepperReady` when the move is complete so the controller can accept the next command. Both axes run in a shared slot schedule, so a move ends on one well-defined cycle.

---
 rtl/scara_stepper_pkg.sv | 29 ++
 rtl/stepper_slot_timer.sv | 41 ++++
 rtl/dual_stepper_driver.sv | 177 +++++++++++++++++
 tb/tb_dual_stepper_driver.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scara_stepper_pkg.sv
// scara_stepper_pkg
// Shared types and defaults for the dual-axis stepper pulse generator.
//   state_t         : controller states (IDLE, SETUP, HIGH, LOW)
//   step_cnt_t      : 8-bit unsigned per-axis step count
//   DEF_HALF_PERIOD : default STEP high/low time in clocks
//   DEF_DIR_SETUP   : default DIR-to-first-STEP setup time in clocks
package scara_stepper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    localparam int DEF_HALF_PERIOD = 2500;
    localparam int DEF_DIR_SETUP   = 500;

    typedef logic [7:0] step_cnt_t;

    function automatic step_cnt_t max_cnt(input step_cnt_t a, input step_cnt_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic step_cnt_t min_cnt(input step_cnt_t a, input step_cnt_t b);
        return (a > b) ? b : a;
    endfunction

endpackage

// File: rtl/stepper_slot_timer.sv
// stepper_slot_timer
// Load-and-count-down phase timer. A load of value V makes expire assert
// V+1 cycles later (for exactly one cycle unless reloaded that same cycle).
// Ports:
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   load     : start a new phase (takes priority over counting)
//   load_val : phase length minus one
//   expire   : high during the final cycle of the phase
module stepper_slot_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count;
    logic             active;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            active <= 1'b0;
        end else if (load) begin
            count  <= load_val;
            active <= 1'b1;
        end else if (active) begin
            if (count == '0) begin
                active <= 1'b0;
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign expire = active && (count == '0);

endmodule

// File: rtl/dual_stepper_driver.sv
// dual_stepper_driver
// Turns a per-move pair of step counts/directions into STEP/DIR pulse
// trains for two joint drivers. Both axes share one slot schedule: each
// slot is HALF_PERIOD cycles high then HALF_PERIOD cycles low, and the
// move runs max(steps1, steps2) slots after a DIR_SETUP settling period.
// Build option:
//   SCARA_STEP_INTERP_EN : Bresenham spreading of the minor axis over the
//                          major-axis slots; otherwise the minor axis fires
//                          in the first slots of the move.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   steps1/2, dir1/2     : move command, captured when dataReady in IDLE
//   dataReady            : load strobe (ignored while a move runs)
//   step1/2              : registered STEP outputs
//   dirOut1/2            : registered DIR outputs, change only on a load
//   stepperReady / busy  : idle indication and its complement
module dual_stepper_driver
    import scara_stepper_pkg::*;
#(
    parameter int HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int DIR_SETUP   = DEF_DIR_SETUP
) (
    input  logic      clk,
    input  logic      reset,
    input  step_cnt_t steps1,
    input  step_cnt_t steps2,
    input  logic      dir1,
    input  logic      dir2,
    input  logic      dataReady,
    output logic      step1,
    output logic      step2,
    output logic      dirOut1,
    output logic      dirOut2,
    output logic      stepperReady,
    output logic      busy
);

    localparam int MAX_PH = (HALF_PERIOD > DIR_SETUP) ? HALF_PERIOD : DIR_SETUP;
    localparam int CNT_W  = ($clog2(MAX_PH) < 1) ? 1 : $clog2(MAX_PH);
    localparam logic [CNT_W-1:0] HP_LD = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] DS_LD = CNT_W'(DIR_SETUP - 1);

    state_t           state;
    step_cnt_t        k;
    step_cnt_t        major_q;
    logic             start;
    logic             last_slot;
    logic             hi_entry;
    logic             to_idle;
    logic             tmr_load;
    logic             tmr_expire;
    logic [CNT_W-1:0] tmr_val;
    logic             fire1;
    logic             fire2;

    assign start     = (state == IDLE) && dataReady;
    assign last_slot = ({1'b0, k} + 9'd1) == {1'b0, major_q};

    // Phase-end decisions; SETUP and LOW both either open a HIGH phase or end the move.
    assign hi_entry = tmr_expire &&
                      (((state == SETUP) && (major_q != '0)) || ((state == LOW) && !last_slot));
    assign to_idle  = tmr_expire &&
                      (((state == SETUP) && (major_q == '0)) || ((state == LOW) && last_slot));

    // Every phase boundary except the return to IDLE reloads the timer.
    assign tmr_load = start || (tmr_expire && (state != IDLE) && !to_idle);
    assign tmr_val  = start ? DS_LD : HP_LD;

    stepper_slot_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .expire  (tmr_expire)
    );

`ifdef SCARA_STEP_INTERP_EN
    step_cnt_t          minor_q;
    logic               axis1_major_q;
    logic signed [8:0]  err_q;
    logic signed [8:0]  err_nxt;
    logic signed [9:0]  err_sub;
    logic               minor_fire;

    // One Bresenham step for the slot about to start; err stays within 9-bit signed.
    always_comb begin
        err_sub    = $signed({err_q[8], err_q}) - $signed({2'b00, minor_q});
        minor_fire = err_sub[9];
        if (minor_fire) begin
            err_sub = err_sub + $signed({2'b00, major_q});
        end
        err_nxt = err_sub[8:0];
    end

    // On a tie axis1 is major and the minor axis fires every slot as well.
    assign fire1 = axis1_major_q | minor_fire;
    assign fire2 = !axis1_major_q | minor_fire;

    always_ff @(posedge clk) begin
        if (start) begin
            major_q       <= max_cnt(steps1, steps2);
            minor_q       <= min_cnt(steps1, steps2);
            axis1_major_q <= (steps1 >= steps2);
            err_q         <= $signed({1'b0, max_cnt(steps1, steps2) >> 1});
        end else if (hi_entry) begin
            err_q <= err_nxt;
        end
    end
`else
    step_cnt_t steps1_q;
    step_cnt_t steps2_q;
    step_cnt_t slot_next;

    // Index of the slot being entered: 0 out of SETUP, k+1 out of LOW.
    assign slot_next = (state == SETUP) ? '0 : (k + 8'd1);
    assign fire1     = slot_next < steps1_q;
    assign fire2     = slot_next < steps2_q;

    always_ff @(posedge clk) begin
        if (start) begin
            steps1_q <= steps1;
            steps2_q <= steps2;
            major_q  <= max_cnt(steps1, steps2);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            k            <= '0;
            step1        <= 1'b0;
            step2        <= 1'b0;
            dirOut1      <= 1'b0;
            dirOut2      <= 1'b0;
            stepperReady <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (dataReady) begin
                        dirOut1      <= dir1;
                        dirOut2      <= dir2;
                        k            <= '0;
                        stepperReady <= 1'b0;
                        state        <= SETUP;
                    end
                end
                SETUP, LOW: begin
                    if (hi_entry) begin
                        step1 <= fire1;
                        step2 <= fire2;
                        if (state == LOW) begin
                            k <= k + 8'd1;
                        end
                        state <= HIGH;
                    end else if (to_idle) begin
                        stepperReady <= 1'b1;
                        state        <= IDLE;
                    end
                end
                HIGH: begin
                    if (tmr_expire) begin
                        step1 <= 1'b0;
                        step2 <= 1'b0;
                        state <= LOW;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = ~stepperReady;

endmodule

// File: tb/tb_dual_stepper_driver.sv
// tb_dual_stepper_driver
// Directed bench for dual_stepper_driver with HALF_PERIOD=4, DIR_SETUP=8.
// Each load pushes the cycle numbers of the expected STEP and stepperReady
// edges into per-signal queues; a negedge monitor pops them as edges occur.
module tb_dual_stepper_driver;

    localparam int HP = 4;
    localparam int DS = 8;

    logic       clk;
    logic       reset;
    logic [7:0] steps1;
    logic [7:0] steps2;
    logic       dir1;
    logic       dir2;
    logic       dataReady;
    logic       step1;
    logic       step2;
    logic       dirOut1;
    logic       dirOut2;
    logic       stepperReady;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic mon_en = 1'b0;
    logic p1, p2, pr;
    int   q [3][$];

    dual_stepper_driver #(
        .HALF_PERIOD(HP),
        .DIR_SETUP  (DS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .steps1      (steps1),
        .steps2      (steps2),
        .dir1        (dir1),
        .dir2        (dir2),
        .dataReady   (dataReady),
        .step1       (step1),
        .step2       (step2),
        .dirOut1     (dirOut1),
        .dirOut2     (dirOut2),
        .stepperReady(stepperReady),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic track(input int a, input logic now, input logic prev, input string tag);
        int e;
        if (now !== prev) begin
            if (q[a].size() == 0) begin
                chk({tag, "_unexpected"}, cyc, 32'hFFFF_FFFF);
            end else begin
                e = q[a].pop_front();
                chk(tag, cyc, e);
            end
        end else if (q[a].size() != 0 && q[a][0] < cyc) begin
            e = q[a].pop_front();
            chk({tag, "_missed"}, cyc, e);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy_vs_ready", busy, !stepperReady);
            track(0, step1, p1, "step1_edge");
            track(1, step2, p2, "step2_edge");
            track(2, stepperReady, pr, "ready_edge");
        end
        p1 <= step1;
        p2 <= step2;
        pr <= stepperReady;
    end

    function automatic int pending();
        return q[0].size() + q[1].size() + q[2].size();
    endfunction

    // Drive a load on the next edge and queue the expected edges (masks: bit s = fires in slot s).
    task automatic do_load(input logic [7:0] s1, input logic [7:0] s2, input logic d1,
                           input logic d2, input logic [7:0] m1, input logic [7:0] m2);
        int n;
        int major;
        major     = (s1 > s2) ? int'(s1) : int'(s2);
        steps1    = s1;
        steps2    = s2;
        dir1      = d1;
        dir2      = d2;
        dataReady = 1'b1;
        n         = cyc + 1;
        if (mon_en) begin
            q[2].push_back(n);
            q[2].push_back(n + DS + 2 * HP * major);
            for (int s = 0; s < 8; s++) begin
                if (m1[s]) begin
                    q[0].push_back(n + DS + 2 * HP * s);
                    q[0].push_back(n + DS + 2 * HP * s + HP);
                end
                if (m2[s]) begin
                    q[1].push_back(n + DS + 2 * HP * s);
                    q[1].push_back(n + DS + 2 * HP * s + HP);
                end
            end
        end
        @(posedge clk);
        #1;
        dataReady = 1'b0;
        chk("dirOut1_load", dirOut1, d1);
        chk("dirOut2_load", dirOut2, d2);
        chk("busy_after_load", busy, 1'b1);
    endtask

    // Strobe while busy; the outputs must keep the directions of the running move.
    task automatic strobe_busy(input logic [7:0] s1, input logic [7:0] s2, input logic d1,
                               input logic d2, input logic e1, input logic e2);
        steps1    = s1;
        steps2    = s2;
        dir1      = d1;
        dir2      = d2;
        dataReady = 1'b1;
        @(posedge clk);
        #1;
        dataReady = 1'b0;
        chk("dirOut1_ignored", dirOut1, e1);
        chk("dirOut2_ignored", dirOut2, e2);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && pending() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("events_drained", pending(), 0);
    endtask

    initial begin
        reset     = 1'b0;
        steps1    = '0;
        steps2    = '0;
        dir1      = 1'b0;
        dir2      = 1'b0;
        dataReady = 1'b0;

        // Reset held: reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_step1", step1, 1'b0);
        chk("rst_step2", step2, 1'b0);
        chk("rst_dirOut1", dirOut1, 1'b0);
        chk("rst_dirOut2", dirOut2, 1'b0);
        chk("rst_ready", stepperReady, 1'b1);
        chk("rst_busy", busy, 1'b0);

        // Released with no load: stays ready.
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("idle_ready", stepperReady, 1'b1);
            chk("idle_step1", step1, 1'b0);
        end
        mon_en = 1'b1;

        // 3/3, dir 1/0: simultaneous pulses, busy 32 cycles; strobe mid-move ignored.
        do_load(8'd3, 8'd3, 1'b1, 1'b0, 8'h07, 8'h07);
        repeat (10) @(posedge clk);
        #1;
        strobe_busy(8'd9, 8'd9, 1'b0, 1'b1, 1'b1, 1'b0);
        drain(150);

        // 4/2 issued back-to-back with the previous completion.
`ifdef SCARA_STEP_INTERP_EN
        do_load(8'd4, 8'd2, 1'b0, 1'b1, 8'h0F, 8'h0A);
`else
        do_load(8'd4, 8'd2, 1'b0, 1'b1, 8'h0F, 8'h03);
`endif
        drain(150);

        // 2/5: axis 2 is the major axis.
`ifdef SCARA_STEP_INTERP_EN
        do_load(8'd2, 8'd5, 1'b1, 1'b1, 8'h0A, 8'h1F);
`else
        do_load(8'd2, 8'd5, 1'b1, 1'b1, 8'h03, 8'h1F);
`endif
        repeat (20) @(posedge clk);
        #1;
        strobe_busy(8'd1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        drain(150);

        // 0/0: no pulses, ready returns after DIR_SETUP.
        do_load(8'd0, 8'd0, 1'b0, 1'b0, 8'h00, 8'h00);
        drain(50);

        // Reset in the middle of a 5/5 HIGH phase.
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        do_load(8'd5, 8'd5, 1'b1, 1'b1, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        strobe_busy(8'd1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_high_step1", step1, 1'b1);
        chk("mid_high_step2", step2, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_step1", step1, 1'b0);
        chk("async_step2", step2, 1'b0);
        chk("async_ready", stepperReady, 1'b1);
        chk("async_busy", busy, 1'b0);
        chk("async_dirOut1", dirOut1, 1'b0);
        chk("async_dirOut2", dirOut2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_ready", stepperReady, 1'b1);
            chk("post_rst_step1", step1, 1'b0);
        end
        mon_en = 1'b1;

        // 1/0 after reset: exactly one step1 pulse.
        do_load(8'd1, 8'd0, 1'b1, 1'b0, 8'h01, 8'h00);
        drain(50);
        repeat (20) @(posedge clk);
        #1;
        chk("final_ready", stepperReady, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
